// File: rtl/ahbl_sram_ctrl_if.sv
// rtl/ahbl_sram_ctrl_if.sv - AHB-Lite bus bundle between a manager and the SRAM controller
interface ahbl_sram_ctrl_if;
  // Address-phase controls plus write data, driven by the manager
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  // Subordinate response
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahbl_sram_ctrl.sv
// rtl/ahbl_sram_ctrl.sv - AHB-Lite subordinate driving a single-port synchronous SRAM
module ahbl_sram_ctrl #(
  parameter int AW    = 12,
  parameter int DEPTH = 3072
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahbl_sram_ctrl_if.slave     ahb,
  input  logic [31:0]         SRAMRDATA,
  output logic [3:0]          SRAMWEN,
  output logic [31:0]         SRAMWDATA,
  output logic                SRAMCS0,
  output logic [AW-1:0]       SRAMADDR
);

  // Each state names the data phase currently in progress on the bus.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RWAIT = 3'd3,
    ERR1  = 3'd4,
    ERR2  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] waddr_q;
  logic [AW-1:0] raddr_q;
  logic [3:0]    wmask_q;

  logic          acc;
  logic          accepting;
  logic          bad;
  logic [AW-1:0] word_addr;
  logic [3:0]    byte_mask;
  logic          wr_cap;
  logic          rd_cap;
  logic          cs_raw;
  logic [3:0]    wen_raw;
  logic [AW-1:0] addr_raw;
  logic          unused_haddr;

  // Bits above the decoded window carry no meaning for this RAM.
  assign unused_haddr = ^ahb.HADDR[31:AW+2];

  assign word_addr = ahb.HADDR[AW+1:2];
  assign acc       = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  // States that can take a new address phase; RWAIT and ERR1 hold HREADY low.
  assign accepting = (state == IDLE) || (state == WRITE) ||
                     (state == READ) || (state == ERR2);

  // Address-phase legality: size, alignment and populated depth.
  always_comb begin
    bad = 1'b0;
    if (ahb.HSIZE > 3'd2) bad = 1'b1;
    if ((ahb.HSIZE == 3'd1) && ahb.HADDR[0]) bad = 1'b1;
    if ((ahb.HSIZE == 3'd2) && (ahb.HADDR[1:0] != 2'b00)) bad = 1'b1;
    if (32'(word_addr) >= 32'(DEPTH)) bad = 1'b1;
  end

  // Byte-lane enables derived from size and the low address bits.
  always_comb begin
    byte_mask = 4'hF;
    case (ahb.HSIZE)
      3'd0:    byte_mask = 4'b0001 << ahb.HADDR[1:0];
      3'd1:    byte_mask = 4'b0011 << {ahb.HADDR[1], 1'b0};
      default: byte_mask = 4'hF;
    endcase
  end

  // Next data phase and the capture strobes for deferred SRAM accesses.
  always_comb begin
    state_nxt = state;
    wr_cap    = 1'b0;
    rd_cap    = 1'b0;
    case (state)
      IDLE, WRITE, READ, ERR2: begin
        if (acc && bad) begin
          state_nxt = ERR1;
        end else if (acc && ahb.HWRITE) begin
          state_nxt = WRITE;
          wr_cap    = 1'b1;
        end else if (acc && (state == WRITE)) begin
          // SRAM port is busy with the write, so park the read address.
          state_nxt = RWAIT;
          rd_cap    = 1'b1;
        end else if (acc) begin
          state_nxt = READ;
        end else begin
          state_nxt = IDLE;
        end
      end
      RWAIT:   state_nxt = READ;
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and captured write/read request fields.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      waddr_q <= '0;
      wmask_q <= 4'h0;
      raddr_q <= '0;
    end else begin
      state <= state_nxt;
      if (wr_cap) begin
        waddr_q <= word_addr;
        wmask_q <= byte_mask;
      end
      if (rd_cap) begin
        raddr_q <= word_addr;
      end
    end
  end

  // SRAM port arbitration: write data phase first, then a parked read, then a fresh read.
  always_comb begin
    cs_raw   = 1'b0;
    wen_raw  = 4'h0;
    addr_raw = '0;
    if (state == WRITE) begin
      cs_raw   = 1'b1;
      wen_raw  = wmask_q;
      addr_raw = waddr_q;
    end else if (state == RWAIT) begin
      cs_raw   = 1'b1;
      addr_raw = raddr_q;
    end else if (accepting && acc && !ahb.HWRITE && !bad) begin
      cs_raw   = 1'b1;
      addr_raw = word_addr;
    end
  end

  // Strobes are forced off while reset is low so nothing reaches the macro mid-reset.
  assign SRAMCS0   = cs_raw & HRESETn;
  assign SRAMWEN   = wen_raw & {4{HRESETn}};
  assign SRAMADDR  = addr_raw;
  assign SRAMWDATA = ahb.HWDATA;

  assign ahb.HRDATA    = (state == READ) ? SRAMRDATA : 32'h0;
  assign ahb.HREADYOUT = !((state == RWAIT) || (state == ERR1));
  assign ahb.HRESP     = (state == ERR1) || (state == ERR2);

endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// tb/tb_ahbl_sram_ctrl.sv - cycle-vector bench for ahbl_sram_ctrl with a behavioural SRAM
module tb_ahbl_sram_ctrl;
  localparam int AW    = 12;
  localparam int DEPTH = 3072;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] NS = 2'b10;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_cs;
    logic [3:0]  e_wen;
    logic [11:0] e_addr;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_rdata;
  } vec_t;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [31:0]   sram_rdata = 32'h0;
  logic [3:0]    SRAMWEN;
  logic [31:0]   SRAMWDATA;
  logic          SRAMCS0;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   mem [0:DEPTH-1];
  logic          mem_ready = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;
  vec_t          vq[$];
  logic [31:0]   sd [8];

  ahbl_sram_ctrl_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahbl_sram_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .ahb       (bus.slave),
    .SRAMRDATA (sram_rdata),
    .SRAMWEN   (SRAMWEN),
    .SRAMWDATA (SRAMWDATA),
    .SRAMCS0   (SRAMCS0),
    .SRAMADDR  (SRAMADDR)
  );

  always #5 HCLK = ~HCLK;

  // Synchronous SRAM: byte writes, read data registered one cycle after CS.
  always @(posedge HCLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      mem_ready <= 1'b1;
    end else if (SRAMCS0 && (int'(SRAMADDR) < DEPTH)) begin
      if (SRAMWEN != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
      end else begin
        sram_rdata <= mem[SRAMADDR];
      end
    end
  end

  function automatic vec_t v(input logic sel, input logic [1:0] tr, input logic wr,
                             input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                             input logic cs, input logic [3:0] wen, input logic [11:0] sa,
                             input logic rdy, input logic resp, input logic [31:0] rd);
    vec_t r;
    r.sel = sel; r.trans = tr; r.wr = wr; r.size = sz; r.addr = a; r.wdata = wd;
    r.e_cs = cs; r.e_wen = wen; r.e_addr = sa; r.e_rdy = rdy; r.e_resp = resp; r.e_rdata = rd;
    return r;
  endfunction

  task automatic drive(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bus.HSEL = sel; bus.HTRANS = tr; bus.HWRITE = wr;
    bus.HSIZE = sz; bus.HADDR = a; bus.HWDATA = wd;
  endtask

  task automatic run_row(input vec_t r, input int idx);
    logic [50:0] act, exp;
    @(posedge HCLK);
    #1;
    drive(r.sel, r.trans, r.wr, r.size, r.addr, r.wdata);
    @(negedge HCLK);
    act = {SRAMCS0, SRAMWEN, SRAMADDR, bus.HREADYOUT, bus.HRESP, bus.HRDATA};
    exp = {r.e_cs, r.e_wen, r.e_addr, r.e_rdy, r.e_resp, r.e_rdata};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row%0d: got cs=%b wen=%b addr=%h rdy=%b resp=%b rdata=%h, required cs=%b wen=%b addr=%h rdy=%b resp=%b rdata=%h",
               idx, SRAMCS0, SRAMWEN, SRAMADDR, bus.HREADYOUT, bus.HRESP, bus.HRDATA,
               r.e_cs, r.e_wen, r.e_addr, r.e_rdy, r.e_resp, r.e_rdata);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic run_queue();
    foreach (vq[i]) run_row(vq[i], i);
    vq.delete();
  endtask

  initial begin
    drive(1'b0, ID, 1'b0, 3'd2, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) sd[i] = 32'hA5000000 + 32'h01010101 * i + 32'h10 * i;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // sel tr wr sz addr wdata | cs wen saddr rdy resp rdata
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 1, 2, 32'h000,  32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 1, 0, 32'h002,  32'h11223344, 1, 4'hF, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 0, 2, 32'h000,  32'h00AA0000, 1, 4'h4, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 0, 2, 32'h000,  32'h0,        1, 4'h0, 12'h000, 0, 0, 32'h0));
    vq.push_back(v(1, NS, 1, 1, 32'h006,  32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h11AA3344));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'hBEEF0000, 1, 4'hC, 12'h001, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 1, 2, 32'h010,  32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 0, 2, 32'h010,  32'hDEADBEEF, 1, 4'hF, 12'h004, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 0, 2, 32'h010,  32'h0,        1, 4'h0, 12'h004, 0, 0, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'h0,        0, 4'h0, 12'h000, 1, 0, 32'hDEADBEEF));
    vq.push_back(v(1, NS, 0, 2, 32'h3000, 32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'h0,        0, 4'h0, 12'h000, 0, 1, 32'h0));
    vq.push_back(v(1, NS, 0, 2, 32'h000,  32'h0,        1, 4'h0, 12'h000, 1, 1, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h11AA3344));
    vq.push_back(v(1, NS, 1, 2, 32'h002,  32'h55555555, 0, 4'h0, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'h66666666, 0, 4'h0, 12'h000, 0, 1, 32'h0));
    vq.push_back(v(1, NS, 1, 3, 32'h000,  32'h0,        0, 4'h0, 12'h000, 1, 1, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'hFFFFFFFF, 0, 4'h0, 12'h000, 0, 1, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'h0,        0, 4'h0, 12'h000, 1, 1, 32'h0));
    vq.push_back(v(1, NS, 0, 2, 32'h000,  32'h0,        1, 4'h0, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 0, 1, 32'h006,  32'h0,        1, 4'h0, 12'h001, 1, 0, 32'h11AA3344));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'h0,        0, 4'h0, 12'h000, 1, 0, 32'hBEEF0000));
    vq.push_back(v(1, BZ, 0, 2, 32'h000,  32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 0, 2, 32'h2FFC, 32'h0,        1, 4'h0, 12'hBFF, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 0, 1, 32'h001,  32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'h0,        0, 4'h0, 12'h000, 0, 1, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'h0,        0, 4'h0, 12'h000, 1, 1, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,    32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h0));
    run_queue();

    // Streaming: 8 writes to 0x100..0x11C, then 8 reads with one RWAIT at the boundary.
    for (int c = 0; c < 8; c++)
      vq.push_back(v(1, NS, 1, 2, 32'h100 + 32'(4 * c), (c > 0) ? sd[(c > 0) ? c - 1 : 0] : 32'h0,
                     (c > 0), (c > 0) ? 4'hF : 4'h0, (c > 0) ? 12'(12'h040 + c - 1) : 12'h000,
                     1, 0, 32'h0));
    vq.push_back(v(1, NS, 0, 2, 32'h100, sd[7], 1, 4'hF, 12'h047, 1, 0, 32'h0));
    vq.push_back(v(1, NS, 0, 2, 32'h100, 32'h0, 1, 4'h0, 12'h040, 0, 0, 32'h0));
    for (int c = 1; c < 8; c++)
      vq.push_back(v(1, NS, 0, 2, 32'h100 + 32'(4 * c), 32'h0,
                     1, 4'h0, 12'(12'h040 + c), 1, 0, sd[c - 1]));
    vq.push_back(v(0, ID, 0, 2, 32'h0, 32'h0, 0, 4'h0, 12'h000, 1, 0, sd[7]));
    // Seed word 8 before the reset test.
    vq.push_back(v(1, NS, 1, 2, 32'h020, 32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,   32'h12345678, 1, 4'hF, 12'h008, 1, 0, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,   32'h0,        0, 4'h0, 12'h000, 1, 0, 32'h0));
    run_queue();

    // Reset asserted in the middle of a write data phase.
    @(posedge HCLK);
    #1;
    drive(1'b1, NS, 1'b1, 3'd2, 32'h020, 32'h0);
    @(posedge HCLK);
    #1;
    drive(1'b0, ID, 1'b0, 3'd2, 32'h0, 32'hCAFEF00D);
    #1;
    check("pre_reset_cs", {31'h0, SRAMCS0}, 32'h1);
    HRESETn = 1'b0;
    #1;
    check("reset_strobes", {24'h0, SRAMCS0, SRAMWEN, bus.HREADYOUT, bus.HRESP, 1'b0},
          {24'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0});
    check("reset_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    check("reset_hold_cs", {31'h0, SRAMCS0}, 32'h0);
    HRESETn = 1'b1;
    vq.push_back(v(1, NS, 0, 2, 32'h020, 32'h0, 1, 4'h0, 12'h008, 1, 0, 32'h0));
    vq.push_back(v(0, ID, 0, 2, 32'h0,   32'h0, 0, 4'h0, 12'h000, 1, 0, 32'h12345678));
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
